// File: rtl/issue_queue.sv
// Unified out-of-order issue queue: dispatch insert, tag wakeup, one-per-cycle select.
// Define ISSUE_QUEUE_AGE_SELECT_EN for oldest-first select; default picks the lowest-index candidate.
module issue_queue #(
  parameter int DEPTH      = 8,
  parameter int PHYS_IDX_W = 6,
  parameter int AL_IDX_W   = 5,
  parameter int PAYLOAD_W  = 32,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int CNT_W     = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [PHYS_IDX_W-1:0] in_phys_rs,
  input  logic [PHYS_IDX_W-1:0] in_phys_rt,
  input  logic                  in_uses_rs,
  input  logic                  in_uses_rt,
  input  logic                  in_rs_ready,
  input  logic                  in_rt_ready,
  input  logic [PHYS_IDX_W-1:0] in_phys_rw,
  input  logic                  in_uses_rw,
  input  logic [AL_IDX_W-1:0]   in_al_id,
  input  logic                  in_color,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  input  logic                  wb0_valid,
  input  logic                  wb1_valid,
  input  logic [PHYS_IDX_W-1:0] wb0_tag,
  input  logic [PHYS_IDX_W-1:0] wb1_tag,
  input  logic                  issue_ready,
  output logic                  issue_valid,
  output logic [PHYS_IDX_W-1:0] issue_phys_rs,
  output logic [PHYS_IDX_W-1:0] issue_phys_rt,
  output logic [PHYS_IDX_W-1:0] issue_phys_rw,
  output logic                  issue_uses_rw,
  output logic [AL_IDX_W-1:0]   issue_al_id,
  output logic                  issue_color,
  output logic                  issue_is_load,
  output logic                  issue_is_store,
  output logic [PAYLOAD_W-1:0]  issue_payload,
  output logic                  full,
  output logic [CNT_W-1:0]      count
);

  typedef struct packed {
    logic [PHYS_IDX_W-1:0] rs;
    logic [PHYS_IDX_W-1:0] rt;
    logic [PHYS_IDX_W-1:0] rw;
    logic                  uses_rw;
    logic [AL_IDX_W-1:0]   al_id;
    logic                  color;
    logic                  is_load;
    logic                  is_store;
    logic [PAYLOAD_W-1:0]  payload;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] valid_q, rs_rdy_q, rt_rdy_q;
  logic [DEPTH-1:0] valid_d, rs_rdy_d, rt_rdy_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] cand;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic             ins_fire, iss_fire;
  entry_t           in_ent, sel_ent;

  function automatic logic wb_hit(input logic [PHYS_IDX_W-1:0] tag);
    return (wb0_valid && wb0_tag == tag) || (wb1_valid && wb1_tag == tag);
  endfunction

`ifdef ISSUE_QUEUE_AGE_SELECT_EN
  // age_q[r][c] set means entry c was already valid when entry r was inserted.
  logic [DEPTH-1:0] age_q [DEPTH];
`endif

  assign cand = valid_q & rs_rdy_q & rt_rdy_q;

  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
      if (cand[i] && !(|(age_q[i] & cand))) sel_idx = IDX_W'(i);
`else
      if (cand[i]) sel_idx = IDX_W'(i);
`endif
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IDX_W'(i);
  end

  assign full        = (count_q == CNT_W'(DEPTH));
  assign count       = count_q;
  assign issue_valid = |cand;
  assign ins_fire    = in_valid && !full && !flush;
  assign iss_fire    = issue_valid && issue_ready && !flush;

  assign sel_ent        = ent_q[sel_idx];
  assign issue_phys_rs  = sel_ent.rs;
  assign issue_phys_rt  = sel_ent.rt;
  assign issue_phys_rw  = sel_ent.rw;
  assign issue_uses_rw  = sel_ent.uses_rw;
  assign issue_al_id    = sel_ent.al_id;
  assign issue_color    = sel_ent.color;
  assign issue_is_load  = sel_ent.is_load;
  assign issue_is_store = sel_ent.is_store;
  assign issue_payload  = sel_ent.payload;

  assign in_ent = '{rs: in_phys_rs, rt: in_phys_rt, rw: in_phys_rw, uses_rw: in_uses_rw,
                    al_id: in_al_id, color: in_color, is_load: in_is_load,
                    is_store: in_is_store, payload: in_payload};

  // Free slot comes from registered valid, so a slot issued this cycle is not reused until next.
  always_comb begin
    valid_d  = valid_q;
    rs_rdy_d = rs_rdy_q;
    rt_rdy_d = rt_rdy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_hit(ent_q[i].rs)) rs_rdy_d[i] = 1'b1;
      if (wb_hit(ent_q[i].rt)) rt_rdy_d[i] = 1'b1;
    end
    if (iss_fire) valid_d[sel_idx] = 1'b0;
    if (ins_fire) begin
      valid_d[free_idx]  = 1'b1;
      rs_rdy_d[free_idx] = !in_uses_rs || in_rs_ready || wb_hit(in_phys_rs);
      rt_rdy_d[free_idx] = !in_uses_rt || in_rt_ready || wb_hit(in_phys_rt);
    end
    if (flush) valid_d = '0;
    count_d = flush ? '0 : count_q + CNT_W'(ins_fire) - CNT_W'(iss_fire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rs_rdy_q <= rs_rdy_d;
      rt_rdy_q <= rt_rdy_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ins_fire) ent_q[free_idx] <= in_ent;
  end

`ifdef ISSUE_QUEUE_AGE_SELECT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) age_q[r] <= '0;
    end else if (ins_fire) begin
      for (int r = 0; r < DEPTH; r++) age_q[r][free_idx] <= 1'b0;
      age_q[free_idx] <= valid_q & ~(DEPTH'(1) << free_idx);
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus randomized traffic against a slot/sequence model.
module tb_issue_queue;
  localparam int DEPTH = 8, PW = 6, AW = 5, DW = 32, CW = 4;

  logic clk = 1'b0, rst_n, flush, in_valid;
  logic [PW-1:0] in_phys_rs, in_phys_rt, in_phys_rw, wb0_tag, wb1_tag;
  logic in_uses_rs, in_uses_rt, in_rs_ready, in_rt_ready, in_uses_rw;
  logic [AW-1:0] in_al_id;
  logic in_color, in_is_load, in_is_store, wb0_valid, wb1_valid, issue_ready;
  logic [DW-1:0] in_payload;
  logic issue_valid, issue_uses_rw, issue_color, issue_is_load, issue_is_store, full;
  logic [PW-1:0] issue_phys_rs, issue_phys_rt, issue_phys_rw;
  logic [AW-1:0] issue_al_id;
  logic [DW-1:0] issue_payload;
  logic [CW-1:0] count;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH), .PHYS_IDX_W(PW), .AL_IDX_W(AW), .PAYLOAD_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_phys_rs(in_phys_rs), .in_phys_rt(in_phys_rt), .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
    .in_rs_ready(in_rs_ready), .in_rt_ready(in_rt_ready), .in_phys_rw(in_phys_rw), .in_uses_rw(in_uses_rw),
    .in_al_id(in_al_id), .in_color(in_color), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_payload(in_payload), .wb0_valid(wb0_valid), .wb1_valid(wb1_valid), .wb0_tag(wb0_tag),
    .wb1_tag(wb1_tag), .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_phys_rs(issue_phys_rs), .issue_phys_rt(issue_phys_rt), .issue_phys_rw(issue_phys_rw),
    .issue_uses_rw(issue_uses_rw), .issue_al_id(issue_al_id), .issue_color(issue_color),
    .issue_is_load(issue_is_load), .issue_is_store(issue_is_store), .issue_payload(issue_payload),
    .full(full), .count(count));

  // Reference: slots with insertion sequence numbers; readiness tracked as plain booleans.
  bit            m_v [DEPTH], m_rsr [DEPTH], m_rtr [DEPTH];
  logic [PW-1:0] m_rs [DEPTH], m_rt [DEPTH], m_rw [DEPTH];
  logic          m_urw [DEPTH], m_col [DEPTH], m_ld [DEPTH], m_st [DEPTH];
  logic [AW-1:0] m_al [DEPTH];
  logic [DW-1:0] m_pl [DEPTH];
  int unsigned   m_seq [DEPTH];
  int unsigned   seq_ctr = 0;

  function automatic int m_select();
    int best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i] && m_rsr[i] && m_rtr[i]) begin
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_v[i]);
    return n;
  endfunction

  function automatic bit hit(input logic [PW-1:0] t);
    return (wb0_valid && wb0_tag == t) || (wb1_valid && wb1_tag == t);
  endfunction

  task automatic model_update();
    int sel = m_select();
    int slot = -1;
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
      return;
    end
    for (int i = DEPTH-1; i >= 0; i--) if (!m_v[i]) slot = i;
    for (int i = 0; i < DEPTH; i++) if (m_v[i]) begin
      if (hit(m_rs[i])) m_rsr[i] = 1;
      if (hit(m_rt[i])) m_rtr[i] = 1;
    end
    if (sel >= 0 && issue_ready) m_v[sel] = 0;
    if (in_valid && slot >= 0) begin
      m_v[slot] = 1; m_seq[slot] = seq_ctr++;
      m_rsr[slot] = !in_uses_rs || in_rs_ready || hit(in_phys_rs);
      m_rtr[slot] = !in_uses_rt || in_rt_ready || hit(in_phys_rt);
      m_rs[slot] = in_phys_rs; m_rt[slot] = in_phys_rt; m_rw[slot] = in_phys_rw;
      m_urw[slot] = in_uses_rw; m_al[slot] = in_al_id; m_col[slot] = in_color;
      m_ld[slot] = in_is_load; m_st[slot] = in_is_store; m_pl[slot] = in_payload;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_phys_rs = 0; in_phys_rt = 0; in_phys_rw = 0;
    in_uses_rs = 0; in_uses_rt = 0; in_rs_ready = 0; in_rt_ready = 0; in_uses_rw = 0;
    in_al_id = 0; in_color = 0; in_is_load = 0; in_is_store = 0; in_payload = 0;
    wb0_valid = 0; wb1_valid = 0; wb0_tag = 0; wb1_tag = 0; issue_ready = 0;
  endtask

  task automatic ins(input logic [PW-1:0] rs, input bit urs, input bit rsr,
                     input logic [PW-1:0] rt, input bit urt, input bit rtr, input logic [AW-1:0] al);
    in_valid = 1; in_phys_rs = rs; in_uses_rs = urs; in_rs_ready = rsr;
    in_phys_rt = rt; in_uses_rt = urt; in_rt_ready = rtr; in_al_id = al;
    in_phys_rw = PW'(al) + 6'd1; in_uses_rw = 1; in_payload = 32'hC0DE_0000 | DW'(al);
  endtask

  task automatic test_reset();
    idle(); rst_n = 0;
    step(); step();
    tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
    tests++; if (count !== 4'd0 || full !== 1'b0) begin fails++; $display("FAIL reset_count got %0d/%b want 0/0", count, full); end
    rst_n = 1; step();
  endtask

  task automatic test_basic();
    ins(6'd5, 1, 1, 6'd0, 0, 0, 5'd3); step(); idle();
    tests++; if (issue_valid !== 1'b1 || issue_al_id !== 5'd3) begin fails++; $display("FAIL basic_issue got v=%b al=%0d want 1/3", issue_valid, issue_al_id); end
    tests++; if (issue_payload !== 32'hC0DE_0003 || issue_phys_rw !== 6'd4) begin fails++; $display("FAIL basic_fields got pl=%h rw=%0d want c0de0003/4", issue_payload, issue_phys_rw); end
    issue_ready = 1; step(); idle();
    tests++; if (count !== 4'd0 || issue_valid !== 1'b0) begin fails++; $display("FAIL basic_drain got cnt=%0d v=%b want 0/0", count, issue_valid); end
  endtask

  task automatic test_wakeup();
    ins(6'd12, 1, 0, 6'd0, 0, 0, 5'd7); step(); idle();
    tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL wake_notready got %b want 0", issue_valid); end
    step();
    tests++; if (issue_valid !== 1'b0 || count !== 4'd1) begin fails++; $display("FAIL wake_hold got v=%b cnt=%0d want 0/1", issue_valid, count); end
    wb1_valid = 1; wb1_tag = 6'd12; step(); idle();
    tests++; if (issue_valid !== 1'b1 || issue_phys_rs !== 6'd12) begin fails++; $display("FAIL wake_issue got v=%b rs=%0d want 1/12", issue_valid, issue_phys_rs); end
    issue_ready = 1; step(); idle();
  endtask

  task automatic test_bypass();
    ins(6'd0, 0, 0, 6'd9, 1, 0, 5'd9); wb0_valid = 1; wb0_tag = 6'd9; step(); idle();
    tests++; if (issue_valid !== 1'b1 || issue_phys_rt !== 6'd9 || issue_al_id !== 5'd9) begin fails++; $display("FAIL bypass got v=%b rt=%0d al=%0d want 1/9/9", issue_valid, issue_phys_rt, issue_al_id); end
    issue_ready = 1; step(); idle();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL bypass_drain got %0d want 0", count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin ins(PW'(20 + i), 1, 0, 6'd0, 0, 0, AW'(i)); step(); end
    idle();
    tests++; if (full !== 1'b1 || count !== 4'd8 || issue_valid !== 1'b0) begin fails++; $display("FAIL full_set got f=%b cnt=%0d v=%b want 1/8/0", full, count, issue_valid); end
    ins(6'd0, 0, 0, 6'd0, 0, 0, 5'd31); step(); idle();
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL full_ignore got %0d want 8", count); end
    wb0_valid = 1; wb0_tag = 6'd23; step(); idle();
    tests++; if (issue_valid !== 1'b1 || issue_al_id !== 5'd3) begin fails++; $display("FAIL full_wake got v=%b al=%0d want 1/3", issue_valid, issue_al_id); end
    ins(6'd0, 0, 0, 6'd0, 0, 0, 5'd30); issue_ready = 1; step(); idle();
    tests++; if (full !== 1'b0 || count !== 4'd7) begin fails++; $display("FAIL full_free got f=%b cnt=%0d want 0/7", full, count); end
    flush = 1; step(); idle();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL full_flush got %0d want 0", count); end
  endtask

  task automatic test_age_order();
    logic [AW-1:0] first_al, second_al;
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
    first_al = 5'd2; second_al = 5'd3;
`else
    first_al = 5'd3; second_al = 5'd2;
`endif
    ins(6'd40, 1, 0, 6'd0, 0, 0, 5'd1); step();
    ins(6'd41, 1, 0, 6'd0, 0, 0, 5'd2); step(); idle();
    wb0_valid = 1; wb0_tag = 6'd40; step(); idle();
    tests++; if (issue_valid !== 1'b1 || issue_al_id !== 5'd1) begin fails++; $display("FAIL age_a got v=%b al=%0d want 1/1", issue_valid, issue_al_id); end
    issue_ready = 1; step(); idle();
    ins(6'd42, 1, 0, 6'd0, 0, 0, 5'd3); step(); idle();
    wb0_valid = 1; wb0_tag = 6'd41; wb1_valid = 1; wb1_tag = 6'd42; step(); idle();
    tests++; if (issue_al_id !== first_al) begin fails++; $display("FAIL age_first got %0d want %0d", issue_al_id, first_al); end
    step();
    tests++; if (issue_al_id !== first_al) begin fails++; $display("FAIL age_stable got %0d want %0d", issue_al_id, first_al); end
    issue_ready = 1; step(); idle();
    tests++; if (issue_valid !== 1'b1 || issue_al_id !== second_al) begin fails++; $display("FAIL age_second got v=%b al=%0d want 1/%0d", issue_valid, issue_al_id, second_al); end
    issue_ready = 1; step(); idle();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL age_drain got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin ins(PW'(50 + i), 1, 0, 6'd0, 0, 0, AW'(10 + i)); step(); end
    idle();
    tests++; if (count !== 4'd5) begin fails++; $display("FAIL flush_pre got %0d want 5", count); end
    ins(6'd0, 0, 0, 6'd0, 0, 0, 5'd20); flush = 1; step(); idle();
    tests++; if (count !== 4'd0 || issue_valid !== 1'b0) begin fails++; $display("FAIL flush_clear got cnt=%0d v=%b want 0/0", count, issue_valid); end
    step();
    tests++; if (count !== 4'd0 || issue_valid !== 1'b0) begin fails++; $display("FAIL flush_absent got cnt=%0d v=%b want 0/0", count, issue_valid); end
  endtask

  task automatic test_random();
    int sel, bad = 0;
    logic [PW*3+AW+4+DW-1:0] got, exp;
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 49) == 0);
      in_valid = $urandom_range(0, 1);
      in_phys_rs = PW'($urandom_range(0, 7)); in_phys_rt = PW'($urandom_range(0, 7));
      in_uses_rs = $urandom_range(0, 1); in_uses_rt = $urandom_range(0, 1);
      in_rs_ready = ($urandom_range(0, 3) == 0); in_rt_ready = ($urandom_range(0, 3) == 0);
      in_phys_rw = PW'($urandom); in_uses_rw = $urandom_range(0, 1); in_al_id = AW'($urandom);
      in_color = $urandom_range(0, 1); in_is_load = $urandom_range(0, 1); in_is_store = $urandom_range(0, 1);
      in_payload = $urandom;
      wb0_valid = ($urandom_range(0, 2) == 0); wb0_tag = PW'($urandom_range(0, 7));
      wb1_valid = ($urandom_range(0, 2) == 0); wb1_tag = PW'($urandom_range(0, 7));
      issue_ready = ($urandom_range(0, 2) != 0);
      step();
      sel = m_select();
      tests++;
      if (issue_valid !== (sel >= 0) || count !== CW'(m_count()) || full !== (m_count() == DEPTH)) begin
        fails++;
        if (bad++ < 10) $display("FAIL rand_state c=%0d got v=%b cnt=%0d f=%b want %b/%0d", c, issue_valid, count, full, sel >= 0, m_count());
      end else if (sel >= 0) begin
        got = {issue_phys_rs, issue_phys_rt, issue_phys_rw, issue_uses_rw, issue_al_id,
               issue_color, issue_is_load, issue_is_store, issue_payload};
        exp = {m_rs[sel], m_rt[sel], m_rw[sel], m_urw[sel], m_al[sel], m_col[sel], m_ld[sel], m_st[sel], m_pl[sel]};
        tests++;
        if (got !== exp) begin
          fails++;
          if (bad++ < 10) $display("FAIL rand_fields c=%0d got %h want %h", c, got, exp);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_age_order();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Unified out-of-order issue queue, directly downstream of the rename/dispatch stage.
- Accepts one renamed instruction per cycle: physical sources and destination, active-list id, colour bit, load/store flags and an opaque execution payload.
- Tracks operand readiness using writeback tag broadcasts (wakeup) and selects one ready instruction per cycle for the execute/AGU stage.
- Its full flag is the issue-queue-full stall input of the rename stage.

Parameters:
- DEPTH, 8: number of queue entries; power of two, ≥2.
- PHYS_IDX_W, 6: width of a physical register index.
- AL_IDX_W, 5: width of an active-list id.
- PAYLOAD_W, 32: width of the opaque payload (ALU control, immediate, pc bits) passed through unchanged.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  mispredict/exception kill; invalidates every entry.
- in_valid  in  1  dispatch strobe; rename asserts it only when full==0.
- in_phys_rs, in_phys_rt  in  PHYS_IDX_W each  physical source tags.
- in_uses_rs, in_uses_rt  in  1 each  source is used; an unused source counts as ready.
- in_rs_ready, in_rt_ready  in  1 each  source valid bit in the register file at dispatch.
- in_phys_rw  in  PHYS_IDX_W  destination tag.
- in_uses_rw  in  1  destination is written.
- in_al_id  in  AL_IDX_W  active-list id.
- in_color  in  1  active-list colour bit.
- in_is_load, in_is_store  in  1 each  memory op class.
- in_payload  in  PAYLOAD_W  opaque payload.
- wb0_valid, wb1_valid  in  1 each  ALU and load writeback broadcasts.
- wb0_tag, wb1_tag  in  PHYS_IDX_W each  broadcast destination tags.
- issue_ready  in  1  downstream accepts this cycle.
- issue_valid  out  1  an issuable entry is presented.
- issue_phys_rs, issue_phys_rt, issue_phys_rw  out  PHYS_IDX_W each  tags of the selected entry.
- issue_uses_rw  out  1  destination used.
- issue_al_id  out  AL_IDX_W  active-list id of the selected entry.
- issue_color  out  1  colour bit of the selected entry.
- issue_is_load, issue_is_store  out  1 each  memory op class.
- issue_payload  out  PAYLOAD_W  payload of the selected entry.
- full  out  1  count==DEPTH.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Per-entry state: valid, rs_rdy, rt_rdy, plus all captured fields.

Reset and flush
- Reset, synchronous, rst_n low at posedge: all valid=0, so issue_valid=0, full=0, count=0. Other outputs are don't-care while issue_valid=0.
- flush at posedge: all valid=0 next cycle. Flush overrides a same-cycle insert and issue; the handshake is still reported downstream if issue_valid&issue_ready were true that cycle.

Insert
- When in_valid && !full && !flush, write the lowest-index invalid entry at posedge.
- rs_rdy = !in_uses_rs | in_rs_ready | (wb0_valid & wb0_tag==in_phys_rs) | (wb1_valid & wb1_tag==in_phys_rs). rt_rdy is computed the same way from the rt fields.
- in_valid while full is ignored (no write, no error).
- full is computed from registered state. A slot freed by an issue in the same cycle is not reusable until the next cycle.

Wakeup
- At each posedge, every valid entry whose rs (rt) tag equals a valid wb tag sets rs_rdy (rt_rdy).
- Both ports may match the same or different entries in the same cycle.
- Tag 0 is not special.

Select and issue
- Select is combinational from registered state.
- Candidate = valid & rs_rdy & rt_rdy. issue_valid = any candidate; issue_* fields come from the selected entry.
- Issue fires when issue_valid && issue_ready: the selected entry's valid clears at posedge.
- issue_* must remain stable while issue_valid && !issue_ready, unless wakeup creates an older candidate (age mode) or flush occurs.

Latency
- Insert at cycle N, already ready: earliest issue at N+1.
- wb broadcast at cycle N: dependent entry earliest issue at N+1.

Count
- count_next = count + insert_fires - issue_fires.
- Insert and issue in the same cycle leave count unchanged.
- Flush sets count to 0.

Optional Feature:
- ISSUE_QUEUE_AGE_SELECT_EN defined: a DEPTH×DEPTH age matrix is maintained. On insert, row[new] = current valid vector excluding new; column[new] is cleared in all other rows. Select picks the candidate with no older candidate (oldest-first).
- Undefined: select picks the lowest-index candidate; no age storage.

Test Plan:
1. Reset, then insert one entry (uses_rs=1, rs_ready=1, uses_rt=0, al_id=3) at cycle 1 → issue_valid=1 at cycle 2 with issue_al_id=3; issue_ready=1 → count returns to 0 at cycle 3.
2. Insert an entry with phys_rs=12 not ready → issue_valid stays 0; wb1_valid=1, wb1_tag=12 at cycle 5 → issue_valid=1 at cycle 6.
3. Same-cycle bypass: insert phys_rt=9 not ready while wb0_tag=9 valid → entry ready; issues the following cycle.
4. Fill 8 entries, none ready → full=1, count=8; a 9th in_valid is ignored; wake one entry and issue it → full=0 the next cycle; the entry inserted that same cycle is not accepted.
5. With AGE_SELECT_EN: insert A into slot 0, B into slot 1, issue A; insert C (reuses slot 0); wake B and C together → B issues first, then C. Without the macro, C (slot 0) issues first.
6. flush asserted alongside in_valid while 5 entries are valid → count=0, issue_valid=0 next cycle; the inserted entry is absent.
